store_fsm: RTL and testbench
============================

// Module: store_fsm
// PURPOSE
//  Microcontroller control unit for the STORE instruction: M[Regi] <= Regj. Complement of the LOAD sequencer.
//  Drives the shared internal bus: address register -> MAR, data register -> MDR, then a memory write cycle.
//  Sits beside the load/fetch sequencers; the top-level controller grants the bus to one sequencer at a time.
// PARAMETERS
//  WR_TIMEOUT  8   max cycles in WRITE awaiting mem_ack before error (>=1)
//  TO_W        4   timeout counter width; must hold WR_TIMEOUT
// PORTS
//  clk             in   1  system clock, rising edge
//  rst_n           in   1  asynchronous, active-low reset
//  start           in   1  request; sampled only in IDLE
//  abort           in   1  sync clear to IDLE (driven by fetch-done); wins over everything except reset
//  addr_sel        in   6  register holding address: 0=R0,1=R1,2=R2,3=R3,4=P0; captured on start accept
//  data_sel        in   6  register holding data, same encoding; captured on start accept
//  mem_ack         in   1  memory write complete
//  src_out_en      out  5  one-hot register bus-drive enable; bit0=R0..bit3=R3, bit4=P0
//  mar_in          out  1  MAR loads from bus
//  mdr_bus_in      out  1  MDR loads from bus
//  mdr_mem_out_en  out  1  MDR drives memory data input
//  en              out  1  memory enable
//  rw              out  1  memory direction; 0=write during WRITE, else 0
//  busy            out  1  high in every state except IDLE
//  done            out  1  one-cycle completion pulse
//  err             out  1  valid with done; 1=illegal select or write timeout
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, captured selects=0, timer=0; every output 0.
//  Moore outputs decoded from state and captured selects only; no input-to-output combinational path.
//  States / outputs (all others 0):
//   IDLE : start=1 -> capture addr_sel,data_sel; if either >4 -> DONE with err_flag=1, else -> ADDR.
//   ADDR : src_out_en=onehot(addr_sel), mar_in=1; -> DATA.
//   DATA : src_out_en=onehot(data_sel), mdr_bus_in=1; -> WRITE, timer cleared.
//   WRITE: en=1, rw=0, mdr_mem_out_en=1; mem_ack=1 -> DONE (err_flag=0);
//          else timer++; timer reaches WR_TIMEOUT-1 without ack -> DONE (err_flag=1).
//   DONE : done=1, err=err_flag; -> IDLE unconditionally.
//  Latency: start accepted at edge N -> ADDR N+1, DATA N+2, WRITE N+3; ack in first WRITE cycle -> done at N+4.
//  At most one src_out_en bit high in any cycle; none in IDLE/WRITE/DONE (no bus contention).
//  start held high: new transaction accepted on the IDLE cycle after DONE (IDLE lasts >=1 cycle).
//  start outside IDLE ignored; selects changing after capture have no effect.
//  mem_ack outside WRITE ignored; ack on the timeout cycle counts as success.
//  abort=1 in any state: next state IDLE, err_flag cleared, no done pulse; same-cycle start ignored.
//  Reset mid-operation: outputs drop to 0 immediately (async), no done pulse.
// STRUCTURE
//  Shared package ctrl_pkg: register select codes (SEL_R0..SEL_P0, SEL_MAX=4), store state enum,
//   one-hot bit positions for src_out_en. Load sequencer uses the same codes.
//  Sub-module reg_sel_decoder: 6-bit code + enable -> 5-bit one-hot + valid; instantiate once,
//   code muxed between captured addr/data select by state.
//  Single state register + timer + 2 capture registers + err_flag; outputs via case on state.
// TESTING
//  addr_sel=1,data_sel=2, ack in 1st WRITE -> src_out_en 00010+mar_in, 00100+mdr_bus_in, en=1 rw=0, done at N+4 err=0.
//  ack never arrives, WR_TIMEOUT=8 -> exactly 8 WRITE cycles, then done=1 err=1, back to IDLE.
//  addr_sel=5 -> done=1 err=1 at N+1, src_out_en/mar_in/en never asserted.
//  abort in 3rd WRITE cycle -> IDLE next cycle, en=0, no done; next start runs normally.
//  rst_n low during DATA -> all outputs 0 same cycle; after release start runs full sequence, err=0.
//  start held high 3 transactions, data_sel=4 -> src_out_en bit4 in each DATA, one IDLE cycle between; one-hot checked every cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control-unit definitions: register select codes, bus-drive bit positions,
// and the store sequencer state encoding. The load sequencer uses the same codes.
package ctrl_pkg;
  localparam int SEL_W   = 6;
  localparam int NUM_SRC = 5;

  localparam logic [SEL_W-1:0] SEL_R0  = 6'd0;
  localparam logic [SEL_W-1:0] SEL_R1  = 6'd1;
  localparam logic [SEL_W-1:0] SEL_R2  = 6'd2;
  localparam logic [SEL_W-1:0] SEL_R3  = 6'd3;
  localparam logic [SEL_W-1:0] SEL_P0  = 6'd4;
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_P0;

  // src_out_en bit index equals the select code of the register it drives
  localparam int SRC_R0_BIT = 0;
  localparam int SRC_R1_BIT = 1;
  localparam int SRC_R2_BIT = 2;
  localparam int SRC_R3_BIT = 3;
  localparam int SRC_P0_BIT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WRITE,
    ST_DONE
  } store_state_t;

  function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
    return sel <= SEL_MAX;
  endfunction
endpackage

// File: rtl/reg_sel_decoder.sv
// Register select code to one-hot bus-drive enable. Illegal codes or a low enable
// produce an all-zero vector with valid low.
module reg_sel_decoder
  import ctrl_pkg::*;
(
  input  logic [SEL_W-1:0]   code,
  input  logic               en,
  output logic [NUM_SRC-1:0] onehot,
  output logic               valid
);
  assign valid = en && sel_legal(code);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_bit
    assign onehot[i] = valid && (code == SEL_W'(i));
  end
endmodule

// File: rtl/store_fsm.sv
// STORE sequencer, M[Regi] <= Regj: address reg -> MAR, data reg -> MDR, then a
// memory write cycle bounded by a timeout. All outputs are Moore-decoded.
module store_fsm
  import ctrl_pkg::*;
#(
  parameter int WR_TIMEOUT = 8,
  parameter int TO_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [SEL_W-1:0]   addr_sel,
  input  logic [SEL_W-1:0]   data_sel,
  input  logic               mem_ack,
  output logic [NUM_SRC-1:0] src_out_en,
  output logic               mar_in,
  output logic               mdr_bus_in,
  output logic               mdr_mem_out_en,
  output logic               en,
  output logic               rw,
  output logic               busy,
  output logic               done,
  output logic               err
);
  store_state_t     state_q, state_d;
  logic [SEL_W-1:0] addr_q, addr_d;
  logic [SEL_W-1:0] data_q, data_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic             err_q, err_d;

  logic [SEL_W-1:0]   dec_code;
  logic               dec_en;
  logic [NUM_SRC-1:0] dec_onehot;
  logic               dec_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    timer_d = timer_q;
    err_d   = err_q;
    if (abort) begin
      state_d = ST_IDLE;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_d = addr_sel;
            data_d = data_sel;
            if (!sel_legal(addr_sel) || !sel_legal(data_sel)) begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              err_d   = 1'b0;
              state_d = ST_ADDR;
            end
          end
        end
        ST_ADDR: state_d = ST_DATA;
        ST_DATA: begin
          timer_d = '0;
          state_d = ST_WRITE;
        end
        ST_WRITE: begin
          // an ack on the final allowed cycle still counts as success
          if (mem_ack) begin
            err_d   = 1'b0;
            state_d = ST_DONE;
          end else if (timer_q == TO_W'(WR_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // One shared decoder: the captured address or data select drives the bus
  assign dec_code = (state_q == ST_DATA) ? data_q : addr_q;
  assign dec_en   = (state_q == ST_ADDR) || (state_q == ST_DATA);

  reg_sel_decoder u_dec (
    .code   (dec_code),
    .en     (dec_en),
    .onehot (dec_onehot),
    .valid  (dec_valid)
  );

  always_comb begin
    src_out_en     = dec_onehot;
    mar_in         = 1'b0;
    mdr_bus_in     = 1'b0;
    mdr_mem_out_en = 1'b0;
    en             = 1'b0;
    rw             = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    err            = 1'b0;
    case (state_q)
      ST_IDLE:  busy = 1'b0;
      ST_ADDR:  mar_in = dec_valid;
      ST_DATA:  mdr_bus_in = dec_valid;
      ST_WRITE: begin
        en             = 1'b1;
        mdr_mem_out_en = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: busy = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_store_fsm.sv
// Store sequencer bench: each accepted request expands into a queue of expected
// per-cycle output records, compared against the DUT on every falling edge.
module tb_store_fsm;
  localparam int WR_TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, mem_ack = 1'b0;
  logic [5:0] addr_sel = '0, data_sel = '0;
  logic [4:0] src_out_en;
  logic       mar_in, mdr_bus_in, mdr_mem_out_en, en, rw, busy, done, err;

  store_fsm #(.WR_TIMEOUT(WR_TIMEOUT), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .addr_sel(addr_sel), .data_sel(data_sel), .mem_ack(mem_ack),
    .src_out_en(src_out_en), .mar_in(mar_in), .mdr_bus_in(mdr_bus_in),
    .mdr_mem_out_en(mdr_mem_out_en), .en(en), .rw(rw), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       idle;
    logic       wr;
    logic       ack;
    logic [4:0] src;
    logic       mar, mdr, mdo, en, busy, done, err;
  } exp_t;

  exp_t q[$];
  exp_t exp_cur;
  int   n_checks = 0;
  int   n_errs   = 0;
  logic chk_en   = 1'b0;

  function automatic exp_t mk(input logic [4:0] src, input logic mar, mdr, mdo, e,
                              input logic bsy, dn, er, wr, ack);
    exp_t x;
    x.idle = !bsy; x.wr = wr; x.ack = ack; x.src = src;
    x.mar = mar; x.mdr = mdr; x.mdo = mdo; x.en = e;
    x.busy = bsy; x.done = dn; x.err = er;
    return x;
  endfunction

  function automatic exp_t idle_exp();
    return mk(5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [12:0] vec(input exp_t x);
    return {x.src, x.mar, x.mdr, x.mdo, x.en, 1'b0, x.busy, x.done, x.err};
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Expand one accepted request into the cycles it must produce after acceptance
  function automatic void push_txn(input logic [5:0] as, ds, input int ack_at);
    logic [4:0] oa, od;
    if (as > 4 || ds > 4) begin
      q.push_back(mk(5'd0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
      return;
    end
    oa = 5'd1 << as;
    od = 5'd1 << ds;
    q.push_back(mk(oa, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    q.push_back(mk(od, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < WR_TIMEOUT; i++) begin
      q.push_back(mk(5'd0, 0, 0, 1, 1, 1, 0, 0, 1, i == ack_at));
      if (i == ack_at) break;
    end
    q.push_back(mk(5'd0, 0, 0, 0, 0, 1, 1, ack_at >= WR_TIMEOUT, 0, 0));
  endfunction

  // Enter the next cycle, fix its expectation, then drive this cycle's inputs
  task automatic step(input logic st, ab, input logic [5:0] as, ds,
                      input int ack_at, input logic noise);
    @(posedge clk); #1;
    exp_cur  = (q.size() == 0) ? idle_exp() : q.pop_front();
    start    = st;
    abort    = ab;
    addr_sel = as;
    data_sel = ds;
    mem_ack  = exp_cur.wr ? exp_cur.ack : noise;
    if (ab) q.delete();
    else if (exp_cur.idle && st) push_txn(as, ds, ack_at);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 6'd0, 6'd0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("outputs", {19'd0, src_out_en, mar_in, mdr_bus_in, mdr_mem_out_en, en, rw, busy, done, err},
          {19'd0, vec(exp_cur)});
      chk("src_onehot", {31'd0, $countones(src_out_en) <= 1}, 32'd1);
    end
  end

  initial begin
    int wcnt, bit4, idles, dn_seen, er_seen;
    exp_cur = idle_exp();
    #2;
    chk("reset_outs", {src_out_en, mar_in, mdr_bus_in, mdr_mem_out_en, en, rw, busy, done, err}, 0);
    #10 rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // addr=R1, data=R2, ack in first WRITE cycle
    step(1, 0, 6'd1, 6'd2, 0, 0);
    step(0, 0, 6'd7, 6'd7, 0, 0);
    chk("t1_addr_src", src_out_en, 5'b00010);
    chk("t1_mar_in", mar_in, 1);
    step(0, 0, 6'd0, 6'd0, 0, 0);
    chk("t1_data_src", src_out_en, 5'b00100);
    chk("t1_mdr_bus_in", mdr_bus_in, 1);
    step(0, 0, 6'd0, 6'd0, 0, 0);
    chk("t1_write_en", {en, rw, mdr_mem_out_en}, 3'b101);
    step(0, 0, 6'd0, 6'd0, 0, 0);
    chk("t1_done_err", {done, err}, 2'b10);
    step(0, 0, 6'd0, 6'd0, 0, 0);
    chk("t1_idle_busy", busy, 0);

    // no ack at all: exactly WR_TIMEOUT write cycles, then error
    step(1, 0, 6'd3, 6'd0, 99, 0);
    wcnt = 0; dn_seen = 0; er_seen = 0;
    for (int i = 0; i < 20 && !dn_seen; i++) begin
      step(0, 0, 6'd0, 6'd0, 0, 0);
      wcnt += en;
      if (done) begin dn_seen = 1; er_seen = err; end
    end
    chk("t2_write_cycles", wcnt, WR_TIMEOUT);
    chk("t2_done_err", {dn_seen[0], er_seen[0]}, 2'b11);

    // illegal address select
    idle(1);
    step(1, 0, 6'd5, 6'd1, 0, 0);
    step(0, 0, 6'd0, 6'd0, 0, 0);
    chk("t3_done_err", {done, err, mar_in, en, src_out_en}, {1'b1, 1'b1, 7'd0});

    // abort in third write cycle
    idle(2);
    step(1, 0, 6'd0, 6'd3, 99, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 6'd0, 6'd0, 0, 0);
    step(0, 1, 6'd0, 6'd0, 0, 0);
    chk("t4_abort_write", en, 1);
    step(0, 0, 6'd0, 6'd0, 0, 0);
    chk("t4_after_abort", {en, done, busy}, 3'b000);
    step(1, 0, 6'd2, 6'd1, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 6'd0, 6'd0, 0, 1);

    // reset during DATA
    idle(1);
    step(1, 0, 6'd4, 6'd0, 0, 0);
    step(0, 0, 6'd0, 6'd0, 0, 0);
    step(0, 0, 6'd0, 6'd0, 0, 0);
    chk("t5_in_data", mdr_bus_in, 1);
    #2;
    exp_cur = idle_exp();
    q.delete();
    start = 0; mem_ack = 0;
    rst_n = 1'b0;
    #1;
    chk("t5_reset_outs", {src_out_en, mar_in, mdr_bus_in, mdr_mem_out_en, en, rw, busy, done, err}, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    step(1, 0, 6'd3, 6'd2, 2, 0);
    dn_seen = 0; er_seen = 1;
    for (int i = 0; i < 10 && !dn_seen; i++) begin
      step(0, 0, 6'd0, 6'd0, 0, 0);
      if (done) begin dn_seen = 1; er_seen = err; end
    end
    chk("t5_rerun_done", {dn_seen[0], er_seen[0]}, 2'b10);

    // start held high, three back-to-back transactions from P0
    idle(2);
    bit4 = 0; idles = 0;
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 6'd0, 6'd4, 0, 0);
      bit4  += src_out_en[4];
      idles += !busy;
    end
    chk("t6_p0_drives", bit4, 3);
    chk("t6_idle_cycles", idles, 3);

    // randomized traffic
    idle(3);
    for (int i = 0; i < 1500; i++) begin
      logic [5:0] as, ds;
      as = ($urandom % 8 == 0) ? 6'($urandom_range(5, 63)) : 6'($urandom_range(0, 4));
      ds = ($urandom % 8 == 0) ? 6'($urandom_range(5, 63)) : 6'($urandom_range(0, 4));
      step($urandom % 3 != 0, $urandom % 40 == 0, as, ds,
           $urandom_range(0, WR_TIMEOUT + 2), 1'($urandom));
    end
    idle(12);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
